det_matrix_loader: RTL and testbench
====================================

Name: det_matrix_loader

Overview:
- Sequential front-end that feeds the combinational 4x4 determinant unit (mod_det_4x4).
- Accepts 2x2, 3x3 or 4x4 matrices as a serial stream of 8-bit elements (valid/ready handshake) and assembles them into the 16-element bus the determinant unit consumes.
- Smaller matrices are embedded in an identity-padded 4x4 frame, so the 4x4 unit returns their determinant unchanged.
- Holds the bus stable for one evaluation cycle, then captures the unit's 8-bit result and reports it with a one-cycle valid pulse.

Parameters:
- DATA_W, 8, element and result width; all arithmetic is modulo 2^DATA_W.
- N_MAX, 4, fixed frame dimension; only 4 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- cmd_size  in  2  matrix size, sampled with cmd_start: 2'b10 = 2x2, 2'b11 = 3x3, 2'b00 = 4x4, 2'b01 = invalid.
- in_valid  in  1  element stream valid.
- in_data  in  8  element value, row-major order.
- in_ready  out  1  high only in LOAD; an element transfers when in_valid && in_ready.
- mat_flat  out  128  4x4 frame to mod_det_4x4; position k (row-major, k = 4*row + col) occupies bits [8k+7:8k]; k=0 drives port a, k=15 drives port p.
- det_in  in  8  resultado from mod_det_4x4, combinational from mat_flat.
- busy  out  1  high in LOAD, EVAL and DONE.
- res_valid  out  1  one-cycle pulse; res_data is valid in that cycle.
- res_data  out  8  captured determinant mod 256; held until the next capture.
- err_size  out  1  one-cycle pulse when cmd_start arrives with cmd_size = 2'b01.

Behaviour:
- Reset values: state IDLE, mat_flat = 0, res_data = 0, res_valid = 0, err_size = 0, in_ready = 0, busy = 0, element counter = 0. Reset takes priority in every state; asserting it mid-load or mid-eval discards all progress and produces no res_valid.
- States: IDLE -> LOAD -> EVAL -> DONE -> IDLE.
- IDLE, cmd_start with a valid size:
  - Latch N (2, 3 or 4) and clear the counter.
  - Preload mat_flat with the pad pattern: all zero, except diagonal positions (i,i) for i < 4-N set to 1. For N=2 that is k=0 and k=5; for N=3 it is k=0; for N=4 nothing.
  - Go to LOAD.
- IDLE, cmd_start with cmd_size = 2'b01: pulse err_size next cycle, stay in IDLE, leave mat_flat and res_data untouched.
- LOAD:
  - Each accepted element number e (0..N*N-1), with r = e div N and c = e mod N, writes frame position (r+4-N, c+4-N).
  - Gaps in in_valid stall the load indefinitely; there is no timeout.
  - On acceptance of element N*N-1, go to EVAL. in_ready drops in the cycle after the last transfer.
- EVAL: one cycle; mat_flat is stable. At the closing edge, res_data <= det_in and the state moves to DONE.
- DONE: res_valid = 1 for exactly one cycle, then return to IDLE.
- Latency: last element accepted at edge T; EVAL is cycle T..T+1; res_valid is high in the cycle after edge T+1.
- mat_flat holds the last frame after DONE until the next valid cmd_start.
- cmd_start while busy is ignored: no error and no state change.
- cmd_start is accepted in the IDLE cycle directly after DONE (back-to-back operations are allowed).
- Arithmetic: wrap-around mod 256, no saturation and no overflow flag. Negative determinants appear in two's complement (e.g. -2 -> 0xFE).
- in_valid outside LOAD is ignored; those elements are not consumed.

Test Plan:
- Reset, then size 2'b10, stream 3,5,2,7 -> frame k0=1, k5=1, k10=3, k11=5, k14=2, k15=7, all other positions 0; res_data = 0x0B, res_valid high one cycle, two cycles after the last element.
- Size 2'b10, stream 1,2,3,4 -> res_data = 0xFE (wrap of -2).
- Size 2'b11, stream 2,0,0,0,3,0,0,0,4 with in_valid low for 3 cycles between elements -> in_ready holds through the gaps; res_data = 0x18.
- Size 2'b00, diagonal 4,4,4,4 with all other elements 0 -> res_data = 0x00 (256 wraps); a second cmd_start issued in the IDLE cycle right after DONE, with diagonal 1,2,3,4 -> res_data = 0x18.
- cmd_start with size 2'b01 -> err_size pulses once, busy stays 0, in_ready stays 0, res_data unchanged.
- Assert reset after 5 of 16 elements -> all outputs return to reset values, no res_valid; a fresh 4x4 load afterwards completes correctly.

Source files
------------

// File: rtl/det_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : det_matrix_loader
// Description : Serial loader that frames 2x2/3x3/4x4 matrices into an
//               identity-padded 4x4 bus for mod_det_4x4 and captures its result.
// Revision    : 1.0 - initial release
// ============================================================================
module det_matrix_loader #(
    parameter int DATA_W = 8,
    parameter int N_MAX  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_start,
    input  logic [1:0]                      cmd_size,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    output logic [N_MAX*N_MAX*DATA_W-1:0]   mat_flat,
    input  logic [DATA_W-1:0]               det_in,
    output logic                            busy,
    output logic                            res_valid,
    output logic [DATA_W-1:0]               res_data,
    output logic                            err_size
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_EVAL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]                    r_state;
    logic [1:0]                    r_row;
    logic [1:0]                    r_col;
    logic [1:0]                    r_off;   // 4-N: top-left corner of the embedded block
    logic [1:0]                    r_last;  // N-1
    logic [N_MAX*N_MAX*DATA_W-1:0] r_mat;
    logic [DATA_W-1:0]             r_res_data;
    logic                          r_res_valid;
    logic                          r_err_size;

    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [3:0] w_k;

    assign w_row = r_row + r_off;
    assign w_col = r_col + r_off;
    assign w_k   = {w_row, w_col};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_off       <= 2'd0;
            r_last      <= 2'd3;
            r_mat       <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_err_size  <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_err_size  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cmd_start) begin
                        r_row <= 2'd0;
                        r_col <= 2'd0;
                        case (cmd_size)
                            2'b10: begin
                                r_off                   <= 2'd2;
                                r_last                  <= 2'd1;
                                r_mat                   <= '0;
                                r_mat[0 +: DATA_W]      <= DATA_W'(1);
                                r_mat[5*DATA_W +: DATA_W] <= DATA_W'(1);
                                r_state                 <= c_LOAD;
                            end
                            2'b11: begin
                                r_off              <= 2'd1;
                                r_last             <= 2'd2;
                                r_mat              <= '0;
                                r_mat[0 +: DATA_W] <= DATA_W'(1);
                                r_state            <= c_LOAD;
                            end
                            2'b00: begin
                                r_off   <= 2'd0;
                                r_last  <= 2'd3;
                                r_mat   <= '0;
                                r_state <= c_LOAD;
                            end
                            default: r_err_size <= 1'b1;
                        endcase
                    end
                end
                c_LOAD: begin
                    if (in_valid) begin
                        r_mat[w_k*DATA_W +: DATA_W] <= in_data;
                        if (r_col == r_last) begin
                            r_col <= 2'd0;
                            if (r_row == r_last) begin
                                r_state <= c_EVAL;
                            end else begin
                                r_row <= r_row + 2'd1;
                            end
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                end
                c_EVAL: begin
                    r_res_data  <= det_in;
                    r_res_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_LOAD);
    assign busy      = (r_state != c_IDLE);
    assign mat_flat  = r_mat;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign err_size  = r_err_size;

endmodule
`default_nettype wire

// File: tb/tb_det_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_det_matrix_loader
// Description : Directed self-checking bench; models mod_det_4x4 behaviourally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_det_matrix_loader;

    logic         clk;
    logic         reset;
    logic         cmd_start;
    logic [1:0]   cmd_size;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [127:0] mat_flat;
    logic [7:0]   det_in;
    logic         busy;
    logic         res_valid;
    logic [7:0]   res_data;
    logic         err_size;

    int n_cmp;
    int n_bad;

    det_matrix_loader #(.DATA_W(8), .N_MAX(4)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_size(cmd_size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mat_flat(mat_flat), .det_in(det_in), .busy(busy),
        .res_valid(res_valid), .res_data(res_data), .err_size(err_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4x4 determinant (cofactor expansion along row 0), mod 256
    function automatic logic [7:0] det4(input logic [127:0] m);
        int e[16];
        int mn[9];
        int d, d3, idx;
        for (int k = 0; k < 16; k++) e[k] = int'(m[8*k +: 8]);
        d = 0;
        for (int j = 0; j < 4; j++) begin
            idx = 0;
            for (int r = 1; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (c != j) begin
                        mn[idx] = e[4*r+c];
                        idx++;
                    end
            d3 = mn[0]*(mn[4]*mn[8]-mn[5]*mn[7]) - mn[1]*(mn[3]*mn[8]-mn[5]*mn[6])
               + mn[2]*(mn[3]*mn[7]-mn[4]*mn[6]);
            if (j % 2 == 1) d = d - e[j]*d3;
            else            d = d + e[j]*d3;
        end
        return d[7:0];
    endfunction

    assign det_in = det4(mat_flat);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] size);
        cmd_start = 1'b1;
        cmd_size  = size;
        tick();
        cmd_start = 1'b0;
    endtask

    // Streams n*n elements, gap idle cycles between them, then checks latency/result
    task automatic stream_and_check(input string name, input int n, input logic [7:0] el[16],
                                    input int gap, input logic [7:0] exp_det);
        for (int e = 0; e < n*n; e++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s in_ready before elem %0d: got %b want 1", name, e, in_ready);
            end
            in_valid = 1'b1;
            in_data  = el[e];
            tick();
            in_valid = 1'b0;
            if (e != n*n-1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    n_cmp++;
                    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s gap hold: in_ready=%b res_valid=%b want 1/0",
                                 name, in_ready, res_valid);
                    end
                end
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s eval cycle: in_ready=%b res_valid=%b busy=%b want 0/0/1",
                     name, in_ready, res_valid, busy);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== exp_det) begin
            n_bad++;
            $display("FAIL %s result: res_valid=%b res_data=%h want 1/%h",
                     name, res_valid, res_data, exp_det);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== exp_det) begin
            n_bad++;
            $display("FAIL %s post-done: res_valid=%b busy=%b res_data=%h want 0/0/%h",
                     name, res_valid, busy, res_data, exp_det);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_cmp++;
        if (mat_flat !== 128'h0 || res_data !== 8'h00 || res_valid !== 1'b0 ||
            err_size !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: mat=%h res=%h rv=%b err=%b rdy=%b busy=%b want all 0",
                     name, mat_flat, res_data, res_valid, err_size, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_idle_zero("reset_state");
    endtask

    task automatic test_2x2();
        logic [7:0]   el[16];
        logic [127:0] exp_mat;
        el = '{default: 8'h00};
        el[0] = 8'd3; el[1] = 8'd5; el[2] = 8'd2; el[3] = 8'd7;
        start_cmd(2'b10);
        exp_mat = '0;
        exp_mat[7:0] = 8'd1;
        exp_mat[47:40] = 8'd1;
        n_cmp++;
        if (mat_flat !== exp_mat || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL 2x2 preload: mat=%h busy=%b want %h/1", mat_flat, busy, exp_mat);
        end
        // a second cmd_start while busy must be ignored
        cmd_start = 1'b1;
        cmd_size  = 2'b01;
        tick();
        cmd_start = 1'b0;
        n_cmp++;
        if (err_size !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_cmd_ignored: err=%b rdy=%b want 0/1", err_size, in_ready);
        end
        stream_and_check("2x2_a", 2, el, 0, 8'h0B);
        exp_mat[87:80] = 8'd3; exp_mat[95:88] = 8'd5;
        exp_mat[119:112] = 8'd2; exp_mat[127:120] = 8'd7;
        n_cmp++;
        if (mat_flat !== exp_mat) begin
            n_bad++;
            $display("FAIL 2x2 frame: got %h want %h", mat_flat, exp_mat);
        end
        el[0] = 8'd1; el[1] = 8'd2; el[2] = 8'd3; el[3] = 8'd4;
        start_cmd(2'b10);
        stream_and_check("2x2_wrap", 2, el, 0, 8'hFE);
    endtask

    task automatic test_3x3_gaps();
        logic [7:0] el[16];
        el = '{default: 8'h00};
        el[0] = 8'd2; el[4] = 8'd3; el[8] = 8'd4;
        // stray in_valid in IDLE must not be consumed
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        in_valid = 1'b0;
        start_cmd(2'b11);
        n_cmp++;
        if (mat_flat !== 128'h1) begin
            n_bad++;
            $display("FAIL 3x3 preload: got %h want %h", mat_flat, 128'h1);
        end
        stream_and_check("3x3_gaps", 3, el, 3, 8'h18);
    endtask

    task automatic test_back_to_back();
        logic [7:0] el[16];
        el = '{default: 8'h00};
        el[0] = 8'd4; el[5] = 8'd4; el[10] = 8'd4; el[15] = 8'd4;
        start_cmd(2'b00);
        stream_and_check("4x4_wrap0", 4, el, 0, 8'h00);
        el[0] = 8'd1; el[5] = 8'd2; el[10] = 8'd3; el[15] = 8'd4;
        start_cmd(2'b00);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back accept: in_ready=%b want 1", in_ready);
        end
        stream_and_check("4x4_b2b", 4, el, 0, 8'h18);
    endtask

    task automatic test_err_size();
        start_cmd(2'b01);
        n_cmp++;
        if (err_size !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: err=%b busy=%b rdy=%b want 1/0/0", err_size, busy, in_ready);
        end
        tick();
        n_cmp++;
        if (err_size !== 1'b0 || busy !== 1'b0 || res_data !== 8'h18 || mat_flat[127:120] !== 8'd4) begin
            n_bad++;
            $display("FAIL err_after: err=%b busy=%b res=%h k15=%h want 0/0/18/04",
                     err_size, busy, res_data, mat_flat[127:120]);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] el[16];
        el = '{default: 8'h00};
        start_cmd(2'b00);
        for (int e = 0; e < 5; e++) begin
            in_valid = 1'b1;
            in_data  = 8'(e + 9);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("reset_midload");
        tick();
        tick();
        check_idle_zero("reset_no_result");
        // upper triangular with diagonal 2,1,3,1 -> det 6
        el[0] = 8'd2; el[1] = 8'd1; el[2] = 8'd1; el[3] = 8'd1;
        el[5] = 8'd1; el[6] = 8'd1; el[7] = 8'd1;
        el[10] = 8'd3; el[11] = 8'd1; el[15] = 8'd1;
        start_cmd(2'b00);
        stream_and_check("4x4_after_reset", 4, el, 1, 8'h06);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        cmd_start = 1'b0;
        cmd_size  = 2'b00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        #2;
        test_reset();
        test_2x2();
        test_3x3_gaps();
        test_back_to_back();
        test_err_size();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
